// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings and framing constants.
// Used by uart_rx; optional parity is enabled with UART_RX_PARITY_EN.
package uart_rx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 217;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        sIDLE      = 3'd0,
        sSTART     = 3'd1,
        sDATA      = 3'd2,
        sPARITY    = 3'd3,
        sSTOP      = 3'd4,
        sWAIT_HIGH = 3'd5
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// The reset value is a parameter so idle-high and idle-low lines both fit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error reporting.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk_25mhz,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

    state_t               state, state_d;
    logic                 rx_s;
    logic [TW-1:0]        timer;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick;
    logic                 frame_bad;
    logic                 load_half;
    logic                 load_full;
    logic                 do_shift;
    logic                 ok_strobe;
    logic                 err_strobe;
`ifdef UART_RX_PARITY_EN
    logic                 do_par;
    logic                 par_err;
`endif

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk_25mhz),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    assign tick = (timer == '0);
    assign busy = (state != sIDLE);

`ifdef UART_RX_PARITY_EN
    assign frame_bad = !rx_s || par_err;
`else
    assign frame_bad = !rx_s;
`endif

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) state <= sIDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        do_shift   = 1'b0;
        ok_strobe  = 1'b0;
        err_strobe = 1'b0;
`ifdef UART_RX_PARITY_EN
        do_par     = 1'b0;
`endif
        unique case (state)
            sIDLE: begin
                if (!rx_s) begin
                    state_d   = sSTART;
                    load_half = 1'b1;
                end
            end
            sSTART: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = sIDLE;
                    end else begin
                        state_d   = sDATA;
                        load_full = 1'b1;
                    end
                end
            end
            sDATA: begin
                if (tick) begin
                    do_shift  = 1'b1;
                    load_full = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = sPARITY;
`else
                        state_d = sSTOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            sPARITY: begin
                if (tick) begin
                    do_par    = 1'b1;
                    load_full = 1'b1;
                    state_d   = sSTOP;
                end
            end
`endif
            sSTOP: begin
                if (tick) begin
                    if (!frame_bad) begin
                        ok_strobe = 1'b1;
                        state_d   = sIDLE;
                    end else begin
                        err_strobe = 1'b1;
                        state_d    = rx_s ? sIDLE : sWAIT_HIGH;
                    end
                end
            end
            sWAIT_HIGH: begin
                if (rx_s) state_d = sIDLE;
            end
            default: state_d = sIDLE;
        endcase
    end

    // Timer is reloaded on every sample, so it never has to wrap.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (load_half) begin
            timer <= HALF;
        end else if (load_full) begin
            timer <= FULL;
        end else if (state == sIDLE || state == sWAIT_HIGH) begin
            timer <= '0;
        end else if (!tick) begin
            timer <= timer - TW'(1);
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state != sDATA) bit_idx <= '0;
            else if (do_shift)  bit_idx <= bit_idx + 3'd1;
            if (do_shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset)       par_err <= 1'b0;
        else if (do_par) par_err <= ^{shreg, rx_s};
    end
`endif

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= ok_strobe;
            frame_err  <= err_strobe;
            if (ok_strobe) data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: table of frames plus hand-written corner cases.
// Build with UART_RX_PARITY_EN to exercise the parity variant at 16 clocks/bit.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int CPB = 16;
`else
    localparam int CPB = 217;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int dv_cycle = 0;
    int start_cycle = 0;
    logic busy_mid = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_25mhz (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt   = dv_cnt + 1;
            dv_cycle = cycle;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (data_valid && frame_err) both_cnt = both_cnt + 1;
    end

    typedef struct {
        logic [7:0] b;
        logic       par_ok;
        int         exp_dv;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is always aligned at posedge+#1, so frames can abut.
    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok,
                              input logic stop_v, input int stop_bits);
        start_cycle = cycle;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (i == 3) busy_mid = busy;
        end
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ !par_ok);
`else
        if (par_ok === 1'bx) $display("note: unknown parity flag");
`endif
        for (int i = 0; i < stop_bits; i++) send_bit(stop_v);
    endtask

    initial begin
        int dv0, fe0, lat, lat_exp, half, glitch;
        logic [7:0] prev;

        lat_exp = (19 * CPB) / 2 + 2;
`ifdef UART_RX_PARITY_EN
        lat_exp = lat_exp + CPB;
`endif
        half   = CPB / 2;
        glitch = (CPB >= 200) ? 50 : CPB / 4;

        vecs.push_back('{8'h55, 1'b1, 1, 0, 8'h55});
        vecs.push_back('{8'h00, 1'b1, 1, 0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 1, 0, 8'hFF});
        vecs.push_back('{8'h81, 1'b1, 1, 0, 8'h81});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1, 0, 8'h07});
        vecs.push_back('{8'h07, 1'b0, 0, 1, 8'h07});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Frames abut with no idle gap between table entries.
        foreach (vecs[i]) begin
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].b, vecs[i].par_ok, 1'b1, 1);
            check($sformatf("v%0d_dv", i), dv_cnt - dv0, vecs[i].exp_dv);
            check($sformatf("v%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
            check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
            check($sformatf("v%0d_busy_mid", i), busy_mid, 1'b1);
            check($sformatf("v%0d_busy_end", i), busy, 1'b0);
            if (vecs[i].exp_dv == 1) begin
                lat = dv_cycle - start_cycle;
                n_checks++;
                if (lat < lat_exp - 4 || lat > lat_exp + 4) begin
                    n_errors++;
                    $display("FAIL v%0d_latency: got %0d expected %0d+-4",
                             i, lat, lat_exp);
                end
            end
        end
        prev = data;

        // Short low glitch on an idle line.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        rx  = 1'b0;
        repeat (glitch) @(posedge clk);
        #1;
        check("glitch_busy_hi", busy, 1'b1);
        rx = 1'b1;
        repeat (half + 12 - glitch) @(posedge clk);
        #1;
        check("glitch_busy_lo", busy, 1'b0);
        check("glitch_dv", dv_cnt - dv0, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_data", data, prev);
        repeat (CPB) @(posedge clk);
        #1;

        // Stop bit held low for three bit times.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'hA3, 1'b1, 1'b0, 3);
        check("brk_fe", fe_cnt - fe0, 1);
        check("brk_dv", dv_cnt - dv0, 0);
        check("brk_data", data, prev);
        check("brk_busy_low", busy, 1'b1);
        send_bit(1'b1);
        check("brk_busy_rel", busy, 1'b0);
        dv0 = dv_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1);
        check("after_brk_dv", dv_cnt - dv0, 1);
        check("after_brk_data", data, 8'h3C);

        // Reset in the middle of bit 4 of 8'hF0.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        repeat (half) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_valid", data_valid, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (CPB - half - 2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("midrst_no_dv", dv_cnt - dv0, 0);
        check("midrst_no_fe", fe_cnt - fe0, 0);
        dv0 = dv_cnt;
        send_frame(8'h0F, 1'b1, 1'b1, 1);
        check("post_rst_dv", dv_cnt - dv0, 1);
        check("post_rst_data", data, 8'h0F);

        repeat (CPB) @(posedge clk);
        #1;
        check("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
